// File: rtl/segcap_pkg.sv
// Shared definitions for segment_capture: FSM state encoding and the
// active-low 7-segment hex pattern table (bits g..a).
package segcap_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of an active-low 7-segment pattern into a hex nibble;
// o_valid is low for any pattern outside the hex table.
module seg_pattern_decode
  import segcap_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_valid  = 1'b0;
    o_nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == SEG_TABLE[i]) begin
        o_valid  = 1'b1;
        o_nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/segment_capture.sv
// Captures a multiplexed 4-digit 7-segment display into hex digits and dp flags.
// Optional rejected-slot counter enabled by defining SEGCAP_ERRCNT_EN.
module segment_capture
  import segcap_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] segment_cathodes,
  input  logic [3:0] digit_anodes,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] decimals,
  output logic       frame_valid,
  output logic       stale,
  output logic [7:0] err_count
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]      STAB_TGT = 8'(STABLE_CYCLES);

  logic [7:0]       r_cath_s1, r_cath_s2;
  logic [3:0]       r_an_s1, r_an_s2;
  logic [11:0]      r_prev;
  logic [11:0]      w_sample;
  state_e           r_state;
  logic [7:0]       r_stab;
  logic [7:0]       w_stab_inc;
  logic [3:0][3:0]  r_shadow, w_shadow_nxt, r_digits;
  logic [3:0]       r_dp, w_dp_nxt, r_seen, w_seen_nxt, r_decimals;
  logic             r_frame_valid;
  logic [TO_W-1:0]  r_to;
  logic [3:0]       w_an_lo;
  logic             w_cap, w_blank, w_multi, w_reject, w_accept, w_frame;
  logic             w_dec_valid;
  logic [3:0]       w_dec_nib;

  // Both buses idle high so reset looks like a blank, undriven display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cath_s1 <= '1;
      r_cath_s2 <= '1;
      r_an_s1   <= '1;
      r_an_s2   <= '1;
    end else begin
      r_cath_s1 <= segment_cathodes;
      r_cath_s2 <= r_cath_s1;
      r_an_s1   <= digit_anodes;
      r_an_s2   <= r_an_s1;
    end
  end

  assign w_sample   = {r_cath_s2, r_an_s2};
  assign w_stab_inc = r_stab + 8'd1;

  // r_prev is frozen through CAPTURE/HOLD so HOLD compares against the captured slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_SETTLE;
      r_stab  <= 8'd0;
      r_prev  <= '1;
    end else begin
      unique case (r_state)
        ST_SETTLE: begin
          r_prev <= w_sample;
          if (w_sample != r_prev) begin
            r_stab <= 8'd1;
          end else begin
            r_stab <= w_stab_inc;
            if (w_stab_inc == STAB_TGT) r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: r_state <= ST_HOLD;
        ST_HOLD: begin
          if (w_sample != r_prev) begin
            r_state <= ST_SETTLE;
            r_stab  <= 8'd1;
            r_prev  <= w_sample;
          end
        end
        default: r_state <= ST_SETTLE;
      endcase
    end
  end

  seg_pattern_decode u_decode (
    .i_pattern (r_cath_s2[6:0]),
    .o_valid   (w_dec_valid),
    .o_nibble  (w_dec_nib)
  );

  assign w_an_lo  = ~r_an_s2;
  assign w_cap    = (r_state == ST_CAPTURE);
  assign w_blank  = (w_an_lo == 4'd0);
  assign w_multi  = ((w_an_lo & (w_an_lo - 4'd1)) != 4'd0);
  assign w_reject = w_cap && !w_blank && (w_multi || !w_dec_valid);
  assign w_accept = w_cap && !w_blank && !w_reject;

  always_comb begin
    w_shadow_nxt = r_shadow;
    w_dp_nxt     = r_dp;
    w_seen_nxt   = r_seen;
    if (w_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (w_an_lo[i]) begin
          w_shadow_nxt[i] = w_dec_nib;
          w_dp_nxt[i]     = ~r_cath_s2[7];
          w_seen_nxt[i]   = 1'b1;
        end
      end
    end
  end

  assign w_frame = w_accept && (w_seen_nxt == 4'hF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow      <= '0;
      r_dp          <= '0;
      r_seen        <= '0;
      r_digits      <= '0;
      r_decimals    <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_shadow      <= w_shadow_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_valid <= w_frame;
      if (w_frame) begin
        r_seen     <= 4'd0;
        r_digits   <= w_shadow_nxt;
        r_decimals <= w_dp_nxt;
      end else begin
        r_seen <= w_seen_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to <= '0;
    end else if (r_frame_valid) begin
      r_to <= '0;
    end else if (r_to != TO_MAX) begin
      r_to <= r_to + TO_W'(1);
    end
  end

`ifdef SEGCAP_ERRCNT_EN
  logic [7:0] r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 8'd0;
    end else if (w_reject && (r_err != 8'hFF)) begin
      r_err <= r_err + 8'd1;
    end
  end
  assign err_count = r_err;
`else
  assign err_count = 8'd0;
`endif

  assign digit0      = r_digits[0];
  assign digit1      = r_digits[1];
  assign digit2      = r_digits[2];
  assign digit3      = r_digits[3];
  assign decimals    = r_decimals;
  assign frame_valid = r_frame_valid;
  assign stale       = (r_to == TO_MAX);

endmodule

// File: tb/tb_segment_capture.sv
// Scoreboard bench for segment_capture: expected frames are queued as each
// scan is issued and checked by an independent frame_valid monitor.
module tb_segment_capture;

`ifdef SEGCAP_ERRCNT_EN
  localparam int ERR_INC = 1;
`else
  localparam int ERR_INC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] segment_cathodes = 8'hFF;
  logic [3:0] digit_anodes = 4'hF;
  logic [3:0] digit0, digit1, digit2, digit3, decimals;
  logic       frame_valid, stale;
  logic [7:0] err_count;

  int          checks = 0;
  int          errors = 0;
  int          exp_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_got, mon_exp;

  always #5 clk = ~clk;

  segment_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk              (clk),
    .rst              (rst),
    .segment_cathodes (segment_cathodes),
    .digit_anodes     (digit_anodes),
    .digit0           (digit0),
    .digit1           (digit1),
    .digit2           (digit2),
    .digit3           (digit3),
    .decimals         (decimals),
    .frame_valid      (frame_valid),
    .stale            (stale),
    .err_count        (err_count)
  );

  function automatic logic [19:0] frame(input logic [3:0] d0, input logic [3:0] d1,
                                        input logic [3:0] d2, input logic [3:0] d3,
                                        input logic [3:0] dp);
    return {d3, d2, d1, d0, dp};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slot(input logic [7:0] c, input logic [3:0] a, input int n);
    segment_cathodes = c;
    digit_anodes     = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    slot(8'hFF, 4'hF, n);
  endtask

  task automatic scan4(input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3);
    slot(c0, 4'b1110, 10);
    slot(c1, 4'b1101, 10);
    slot(c2, 4'b1011, 10);
    slot(c3, 4'b0111, 10);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digit0"}, digit0, 0);
    chk({tag, "_digit1"}, digit1, 0);
    chk({tag, "_digit2"}, digit2, 0);
    chk({tag, "_digit3"}, digit3, 0);
    chk({tag, "_decimals"}, decimals, 0);
    chk({tag, "_frame_valid"}, frame_valid, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  always @(negedge clk) begin
    if (rst && frame_valid) begin
      checks++;
      mon_got = {digit3, digit2, digit1, digit0, decimals};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got %h expected no frame", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got != mon_exp) begin
          errors++;
          $display("FAIL frame_data: got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    logic tog;
    tog = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stale", stale, 0);
    rst = 1'b1;

    // Inputs change every 2 cycles: never stable long enough to capture.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (i % 2 == 1) begin
        if (tog) begin
          segment_cathodes = 8'hF9; digit_anodes = 4'b1110;
        end else begin
          segment_cathodes = 8'hA4; digit_anodes = 4'b1101;
        end
        tog = ~tog;
      end
      if (i == 998) chk("stale_before_timeout", stale, 0);
    end
    chk("stale_at_timeout", stale, 1);
    chk("toggle_no_digits", digit0, 0);
    blank(10);

    exp_q.push_back(frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000));
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
    blank(10);
    chk("scan1_digit0", digit0, 1);
    chk("scan1_digit3", digit3, 4);
    chk("scan1_stale_cleared", stale, 0);

    exp_q.push_back(frame(4'h1, 4'h2, 4'h8, 4'h4, 4'b0100));
    scan4(8'hF9, 8'hA4, 8'h00, 8'h99);
    blank(10);
    chk("dp_decimals", decimals, 4'b0100);

    exp_q.push_back(frame(4'hA, 4'hB, 4'hC, 4'hF, 4'b0000));
    scan4(8'h88, 8'h83, 8'hC6, 8'h8E);
    blank(10);

    slot(8'hF9, 4'b1110, 10);
    slot(8'h7C, 4'b1101, 10);
    exp_err += ERR_INC;
    slot(8'hB0, 4'b1011, 10);
    slot(8'h99, 4'b0111, 10);
    blank(10);
    chk("invalid_pattern_err", err_count, exp_err);
    exp_q.push_back(frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000));
    slot(8'hA4, 4'b1101, 10);
    blank(10);

    slot(8'hF9, 4'b1100, 10);
    exp_err += ERR_INC;
    chk("multi_anode_err", err_count, exp_err);
    slot(8'hF9, 4'b1111, 10);
    chk("blank_anode_no_err", err_count, exp_err);
    slot(8'hB0, 4'b1011, 10);
    slot(8'h99, 4'b0111, 10);
    blank(10);
    exp_q.push_back(frame(4'h5, 4'h6, 4'h3, 4'h4, 4'b0000));
    slot(8'h92, 4'b1110, 10);
    slot(8'h82, 4'b1101, 10);
    blank(10);
    chk("after_reject_digit1", digit1, 6);

    slot(8'h92, 4'b1110, 10);
    slot(8'h82, 4'b1101, 10);
    slot(8'hF8, 4'b1011, 10);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("midreset");
    exp_err = 0;
    rst = 1'b1;
    slot(8'h99, 4'b0111, 10);
    blank(20);
    chk("post_reset_digit2", digit2, 0);
    chk("post_reset_digit3", digit3, 0);
    chk("post_reset_decimals", decimals, 0);
    chk("post_reset_err", err_count, exp_err);

    chk("frames_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
